banco_registradores_param: RTL

//  Parametrised register file for the datapath. It has 2 combinational read ports
//  and 1 synchronous write port, with an optional hardwired-zero register and

---
 rtl/banco_registradores_param.sv | 85 ++++++++
 1 files changed

// File: rtl/banco_registradores_param.sv
// Parametrised register file: 2 combinational read ports, 1 synchronous write port,
// optional hardwired-zero reg 0, optional write-to-read bypass, sequential clear sweep.
module banco_registradores_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              limpa,
  input  logic              EscreveReg,
  input  logic [ADDR_W-1:0] end_escrita,
  input  logic [DATA_W-1:0] dados_escrita,
  input  logic [ADDR_W-1:0] end_leitura1,
  input  logic [ADDR_W-1:0] end_leitura2,
  output logic [DATA_W-1:0] leitura1,
  output logic [DATA_W-1:0] leitura2,
  output logic              ocupado
);

  localparam int PROF = 2**ADDR_W;

  localparam logic [0:0] LIMPANDO = 1'b0;
  localparam logic [0:0] PRONTO   = 1'b1;

  logic [0:0]        estado;
  logic [ADDR_W-1:0] cont;
  logic [DATA_W-1:0] regs [PROF];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_end;
  logic [DATA_W-1:0] mem_dados;

  assign ocupado = (estado == LIMPANDO);

  // One shared write port: the sweep and the user write never coexist.
  always_comb begin
    mem_we    = 1'b0;
    mem_end   = end_escrita;
    mem_dados = dados_escrita;
    if (estado == LIMPANDO) begin
      if (!limpa) begin
        mem_we    = 1'b1;
        mem_end   = cont;
        mem_dados = '0;
      end
    end else if (!limpa && EscreveReg && !(ZERO_REG != 0 && end_escrita == '0)) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado <= LIMPANDO;
      cont   <= '0;
    end else if (limpa) begin
      estado <= LIMPANDO;
      cont   <= '0;
    end else if (estado == LIMPANDO) begin
      cont <= cont + 1'b1;
      if (&cont) estado <= PRONTO;
    end
  end

  // Array is deliberately not reset; gating on reset_n drops a write caught by reset.
  always_ff @(posedge clock) begin
    if (reset_n && mem_we) regs[mem_end] <= mem_dados;
  end

  function automatic logic [DATA_W-1:0] ler(input logic [ADDR_W-1:0] a);
    if (estado == LIMPANDO)
      return '0;
    else if (ZERO_REG != 0 && a == '0)
      return '0;
    else if (BYPASS != 0 && EscreveReg && !limpa && end_escrita == a)
      return dados_escrita;
    else
      return regs[a];
  endfunction

  always_comb leitura1 = ler(end_leitura1);
  always_comb leitura2 = ler(end_leitura2);

endmodule
